noc_pipe_arbiter: RTL and testbench

- Round-robin, packet-atomic arbiter that shares one PipeOutLast-style NOC output among NUM_REQ PipeInLast-style requesters.
- Sits between request sources and a single NOCDataH consumer; once a requester is granted, it holds the grant until it delivers a beat with last=1.
- Registers the output through a one-entry stage, and provides per-packet beat counting and an overlong-packet sticky flag.

---
 rtl/noc_pipe_arbiter.sv | 176 +++++++++++++++++
 tb/tb_noc_pipe_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_pipe_arbiter.sv
// Packet-atomic round-robin arbiter: NUM_REQ requesters share one registered
// NOCDataH output, with per-packet beat counting and a sticky overlong flag.
module noc_pipe_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_BEATS  = 16
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic [NUM_REQ-1:0]            in_ena,
  output logic [NUM_REQ-1:0]            in_rdy,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_REQ-1:0]            in_last,
  input  logic [NUM_REQ-1:0]            in_req,
  output logic                          out_ena,
  input  logic                          out_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          overlong,
  input  logic                          clr_overlong
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BEATS + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  overlong_q, overlong_d;

  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  sel_last_s;
  logic                  sel_ena_s;
  logic                  slot_free_s;
  logic                  accept_s;
  logic                  found_s;
  logic [IDW-1:0]        pick_s;
  logic                  ovl_set_s;

  assign out_ena     = out_valid_q & out_rdy;
  assign slot_free_s = ~out_valid_q | out_ena;
  assign accept_s    = (state_q == GRANT) & sel_ena_s & slot_free_s;

  // Route the granted requester's lane to the output stage
  always_comb begin
    sel_data_s = '0;
    sel_last_s = 1'b0;
    sel_ena_s  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDW'(i)) begin
        sel_data_s = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last_s = in_last[i];
        sel_ena_s  = in_ena[i];
      end
    end
  end

  // Only the owner sees ready, and only when the output slot can take a beat
  always_comb begin
    in_rdy = '0;
    if (state_q == GRANT) begin
      in_rdy[grant_q] = slot_free_s;
    end else begin
      in_rdy = '0;
    end
  end

  // Round-robin search starting just after the last grant, wrapping around
  always_comb begin
    int idx;
    found_s = 1'b0;
    pick_s  = grant_q;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(grant_q) + k) % NUM_REQ;
      if (!found_s && in_req[idx[IDW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx[IDW-1:0];
      end
    end
  end

  // Arbitration FSM; a grant is released only by an accepted last beat
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = GRANT;
          grant_d = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (accept_s && sel_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output slot, beat counter and overlong flag; a set beats a same-cycle clear
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    beat_cnt_d  = beat_cnt_q;
    ovl_set_s   = 1'b0;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_last_d  = sel_last_s;
      if (sel_last_s) begin
        beat_cnt_d = '0;
      end else begin
        ovl_set_s = (beat_cnt_q >= CW'(MAX_BEATS - 1));
        if (beat_cnt_q != CW'(MAX_BEATS)) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
      end
    end else if (out_ena) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (ovl_set_s) begin
      overlong_d = 1'b1;
    end else if (clr_overlong) begin
      overlong_d = 1'b0;
    end else begin
      overlong_d = overlong_q;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      grant_q     <= IDW'(NUM_REQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      beat_cnt_q  <= '0;
      overlong_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      beat_cnt_q  <= beat_cnt_d;
      overlong_q  <= overlong_d;
    end
  end

  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign grant_id = grant_q;
  assign busy     = (state_q == GRANT);
  assign overlong = overlong_q;

endmodule

// File: tb/tb_noc_pipe_arbiter.sv
// Bench for noc_pipe_arbiter: directed vector table, directed corner sequences,
// and random traffic checked against a packet-level reference model.
module tb_noc_pipe_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic [N-1:0]  in_ena, in_rdy, in_last, in_req;
  logic [N*DW-1:0] in_data;
  logic          out_ena, out_rdy, out_last, busy, overlong, clr_overlong;
  logic [DW-1:0] out_data;
  logic [1:0]    grant_id;
  logic [DW-1:0] lane [N];

  assign in_data = {lane[3], lane[2], lane[1], lane[0]};

  always #5 CLK = ~CLK;

  noc_pipe_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .CLK(CLK), .nRST(nRST), .in_ena(in_ena), .in_rdy(in_rdy), .in_data(in_data),
    .in_last(in_last), .in_req(in_req), .out_ena(out_ena), .out_rdy(out_rdy),
    .out_data(out_data), .out_last(out_last), .grant_id(grant_id), .busy(busy),
    .overlong(overlong), .clr_overlong(clr_overlong)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  ena;
    logic [31:0] d;
    logic        last;
    logic        ordy;
    logic [3:0]  x_rdy;
    logic        x_oe;
    logic [31:0] x_d;
    logic        x_last;
    logic        x_busy;
    logic [1:0]  x_gid;
  } vec_t;

  // Reference model: who owns the output, queued beats in the output slot
  int          m_own, m_gid, m_cnt, m_acc, out_cnt;
  bit          m_ovl;
  logic [DW:0] m_q[$];
  int          acc_log[$];

  // Traffic generator state
  int rem[N];
  int seq[N];
  int p_start, len_lo, len_hi, p_long, p_ena, p_ill, p_clr;

  task automatic m_reset();
    m_own = -1; m_gid = N - 1; m_cnt = 0; m_acc = -1; m_ovl = 1'b0;
    m_q.delete(); acc_log.delete(); out_cnt = 0;
    for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    in_req = '0; in_ena = '0; in_last = '0; clr_overlong = 1'b0; out_rdy = 1'b0;
    for (int i = 0; i < N; i++) lane[i] = '0;
    #2;
    nRST = 1'b1;
    m_reset();
  endtask

  task automatic cycle();
    logic [N-1:0] x_rdy;
    logic         x_oe;
    bit           set;
    int           best, bd, d;
    #1;
    x_oe  = (m_q.size() > 0) && out_rdy;
    x_rdy = '0;
    if (m_own >= 0 && (m_q.size() == 0 || out_rdy)) x_rdy[m_own] = 1'b1;
    chk("in_rdy", 64'(in_rdy), 64'(x_rdy));
    chk("out_ena", 64'(out_ena), 64'(x_oe));
    chk("busy", 64'(busy), 64'(m_own >= 0));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("overlong", 64'(overlong), 64'(m_ovl));
    if (m_q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(m_q[0][DW-1:0]));
      chk("out_last", 64'(out_last), 64'(m_q[0][DW]));
    end
    @(posedge CLK);
    m_acc = -1;
    set = 1'b0;
    if (x_oe) begin void'(m_q.pop_front()); out_cnt++; end
    if (m_own >= 0) begin
      if (in_ena[m_own] && x_rdy[m_own]) begin
        m_acc = m_own;
        acc_log.push_back(m_own);
        m_q.push_back({in_last[m_own], lane[m_own]});
        if (in_last[m_own]) begin
          m_own = -1; m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt >= MB) set = 1'b1;
        end
      end
    end else if (in_req != '0) begin
      best = -1; bd = N;
      for (int r = 0; r < N; r++) begin
        d = (r - m_gid - 1 + 2 * N) % N;
        if (in_req[r] && d < bd) begin bd = d; best = r; end
      end
      m_own = best; m_gid = best;
    end
    if (set) m_ovl = 1'b1;
    else if (clr_overlong) m_ovl = 1'b0;
    #1;
  endtask

  task automatic drive(input logic ordy);
    bit rdy_i;
    out_rdy = ordy;
    clr_overlong = ($urandom_range(99) < p_clr);
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && $urandom_range(99) < p_start)
        rem[i] = ($urandom_range(99) < p_long) ? 18 : int'($urandom_range(len_hi, len_lo));
      in_req[i]  = (rem[i] > 0);
      rdy_i      = (m_own == i) && (m_q.size() == 0 || ordy);
      in_ena[i]  = rdy_i ? ($urandom_range(99) < p_ena) : ($urandom_range(99) < p_ill);
      in_last[i] = (rem[i] == 1);
      lane[i]    = {8'(i), 8'hC0, 16'(seq[i])};
    end
  endtask

  task automatic step(input logic ordy);
    drive(ordy);
    cycle();
    if (m_acc >= 0) begin rem[m_acc]--; seq[m_acc]++; end
  endtask

  vec_t tv[14];
  int   exp_ord[6] = '{0, 1, 2, 3, 0, 1};
  int   exp_bp[8]  = '{1, 1, 1, 1, 2, 2, 2, 2};
  int   cyc;

  initial begin
    tv[0]  = '{4'b0001, 4'b0000, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd3};
    tv[1]  = '{4'b0001, 4'b0001, 32'hA1, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h0,  1'b0, 1'b1, 2'd0};
    tv[2]  = '{4'b0001, 4'b0001, 32'hA2, 1'b0, 1'b1, 4'b0001, 1'b1, 32'hA1, 1'b0, 1'b1, 2'd0};
    tv[3]  = '{4'b0001, 4'b0001, 32'hA3, 1'b1, 1'b1, 4'b0001, 1'b1, 32'hA2, 1'b0, 1'b1, 2'd0};
    tv[4]  = '{4'b0000, 4'b0000, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b1, 32'hA3, 1'b1, 1'b0, 2'd0};
    tv[5]  = '{4'b0000, 4'b0000, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0};
    tv[6]  = '{4'b0100, 4'b0000, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd0};
    tv[7]  = '{4'b0100, 4'b0100, 32'hB1, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2};
    tv[8]  = '{4'b0100, 4'b0000, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b1, 32'hB1, 1'b1, 1'b0, 2'd2};
    tv[9]  = '{4'b0100, 4'b0100, 32'hB2, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2};
    tv[10] = '{4'b0100, 4'b0000, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b1, 32'hB2, 1'b1, 1'b0, 2'd2};
    tv[11] = '{4'b0100, 4'b0100, 32'hB3, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h0,  1'b0, 1'b1, 2'd2};
    tv[12] = '{4'b0000, 4'b0100, 32'hEE, 1'b1, 1'b1, 4'b0000, 1'b1, 32'hB3, 1'b1, 1'b0, 2'd2};
    tv[13] = '{4'b0000, 4'b0000, 32'h0,  1'b0, 1'b1, 4'b0000, 1'b0, 32'h0,  1'b0, 1'b0, 2'd2};

    in_req = '0; in_ena = '0; in_last = '0; out_rdy = 1'b0; clr_overlong = 1'b0;
    for (int i = 0; i < N; i++) lane[i] = '0;
    p_start = 0; len_lo = 1; len_hi = 1; p_long = 0; p_ena = 100; p_ill = 0; p_clr = 0;
    #22 nRST = 1'b1;
    @(posedge CLK); #1;
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_out_ena", 64'(out_ena), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd3);
    chk("rst_overlong", 64'(overlong), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);

    // Directed table: 3-beat packet, then single requester re-granted each packet
    for (int v = 0; v < 14; v++) begin
      in_req = tv[v].req; in_ena = tv[v].ena; in_last = {N{tv[v].last}}; out_rdy = tv[v].ordy;
      for (int i = 0; i < N; i++) lane[i] = tv[v].d;
      #1;
      chk($sformatf("tv%0d_in_rdy", v), 64'(in_rdy), 64'(tv[v].x_rdy));
      chk($sformatf("tv%0d_out_ena", v), 64'(out_ena), 64'(tv[v].x_oe));
      chk($sformatf("tv%0d_busy", v), 64'(busy), 64'(tv[v].x_busy));
      chk($sformatf("tv%0d_grant_id", v), 64'(grant_id), 64'(tv[v].x_gid));
      if (tv[v].x_oe) begin
        chk($sformatf("tv%0d_out_data", v), 64'(out_data), 64'(tv[v].x_d));
        chk($sformatf("tv%0d_out_last", v), 64'(out_last), 64'(tv[v].x_last));
      end
      @(posedge CLK); #1;
    end

    // All four requesting 1-beat packets: strict rotation from requester 0
    do_reset();
    p_start = 100; len_lo = 1; len_hi = 1; p_ena = 100; p_ill = 0;
    cyc = 0;
    while (acc_log.size() < 6 && cyc < 40) begin step(1'b1); cyc++; end
    chk("rr_done", 64'(acc_log.size() >= 6), 64'd1);
    for (int k = 0; k < 6 && k < acc_log.size(); k++)
      chk($sformatf("rr_order%0d", k), 64'(acc_log[k]), 64'(exp_ord[k]));

    // Two 4-beat packets under toggling back-pressure, with stray enables
    do_reset();
    p_start = 0; p_ill = 20; rem[1] = 4; rem[2] = 4;
    cyc = 0;
    while (out_cnt < 8 && cyc < 60) begin step(cyc % 2 == 0); cyc++; end
    chk("bp_delivered", 64'(out_cnt), 64'd8);
    for (int k = 0; k < 8 && k < acc_log.size(); k++)
      chk($sformatf("bp_order%0d", k), 64'(acc_log[k]), 64'(exp_bp[k]));

    // 17-beat packet trips overlong after beat 16; a clear pulse drops it
    do_reset();
    p_ill = 0; rem[3] = 17;
    cyc = 0;
    while (acc_log.size() < 15 && cyc < 40) begin step(1'b1); cyc++; end
    chk("ovl_before16", 64'(overlong), 64'd0);
    step(1'b1);
    chk("ovl_after16", 64'(overlong), 64'd1);
    while (out_cnt < 17 && cyc < 60) begin step(1'b1); cyc++; end
    chk("ovl_forwarded", 64'(out_cnt), 64'd17);
    p_clr = 100; step(1'b1); p_clr = 0;
    chk("ovl_cleared", 64'(overlong), 64'd0);

    // Async reset in the middle of a 5-beat packet
    do_reset();
    rem[0] = 5;
    cyc = 0;
    while (acc_log.size() < 2 && cyc < 20) begin step(1'b1); cyc++; end
    drive(1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("mid_rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_out_ena", 64'(out_ena), 64'd0);
    chk("mid_rst_grant_id", 64'(grant_id), 64'd3);
    do_reset();
    rem[0] = 1;
    cyc = 0;
    while (out_cnt < 1 && cyc < 10) begin step(1'b1); cyc++; end
    chk("post_rst_grant", 64'(grant_id), 64'd0);
    chk("post_rst_delivered", 64'(out_cnt), 64'd1);

    // Random traffic against the reference model
    do_reset();
    p_start = 30; len_lo = 1; len_hi = 5; p_long = 5; p_ena = 80; p_ill = 10; p_clr = 3;
    for (int c = 0; c < 800; c++) step($urandom_range(99) < 75);
    p_start = 0; p_clr = 0; p_ena = 100;
    cyc = 0;
    while ((m_own >= 0 || m_q.size() > 0 || in_req != '0) && cyc < 200) begin step(1'b1); cyc++; end
    chk("rand_drained", 64'(m_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
